// File: rtl/item_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : item_sel_pkg
//  Description : Shared constants, clog2 helper and queue-entry layout for
//                the item selection queue.
//  Revision    : 1.0  initial release
// ============================================================================
package item_sel_pkg;

   localparam int ITEM_ADDR_WIDTH_DEF = 10;
   localparam int NUM_CH_DEF          = 4;
   localparam int FIFO_DEPTH_DEF      = 8;
   localparam int NUM_ITEMS_DEF       = 1000;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   localparam int CH_W_DEF = clog2(NUM_CH_DEF);

   // Queue entry at the default sizing: source channel above item code.
   typedef struct packed {
      logic [CH_W_DEF-1:0]            ch;
      logic [ITEM_ADDR_WIDTH_DEF-1:0] item;
   } item_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Single-grant round-robin arbiter; search starts at ptr_i.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          enable_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          any_grant_o
);

   int w_idx;

   // Walk the channels from ptr_i upward (wrapping) and grant the first requester.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_grant_o = 1'b0;
      w_idx       = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(ptr_i) + k) % N;
         if (enable_i && !any_grant_o && req_i[w_idx]) begin
            any_grant_o    = 1'b1;
            grant_idx_o    = IW'(w_idx);
            grant_o[w_idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/item_select_queue.sv
`default_nettype none
// ============================================================================
//  Module      : item_select_queue
//  Description : Round-robin multi-keypad item selector feeding a
//                first-word-fall-through queue of {channel, code} entries.
//                Out-of-range codes are accepted and flagged, never queued.
//                Optional: define ITEM_SEL_STATS_EN for accept/reject counters.
//  Revision    : 1.0  initial release
// ============================================================================
module item_select_queue
   import item_sel_pkg::*;
#(
   parameter int ITEM_ADDR_WIDTH = ITEM_ADDR_WIDTH_DEF,
   parameter int NUM_CH          = NUM_CH_DEF,
   parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
   parameter int NUM_ITEMS       = NUM_ITEMS_DEF
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic [NUM_CH*ITEM_ADDR_WIDTH-1:0]  sel_item,
   input  logic [NUM_CH-1:0]                  sel_valid,
   output logic [NUM_CH-1:0]                  sel_ready,
   input  logic                               flush,
   output logic [ITEM_ADDR_WIDTH-1:0]         out_item,
   output logic [clog2(NUM_CH)-1:0]           out_ch,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               invalid_pulse,
   output logic [clog2(NUM_CH)-1:0]           invalid_ch,
   output logic [clog2(FIFO_DEPTH):0]         fifo_count
`ifdef ITEM_SEL_STATS_EN
   ,
   output logic [15:0]                        accept_cnt,
   output logic [15:0]                        reject_cnt
`endif
);

   localparam int W   = ITEM_ADDR_WIDTH;
   localparam int CHW = clog2(NUM_CH);
   localparam int AW  = clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [CHW-1:0] ch;
      logic [W-1:0]   item;
   } entry_t;

   entry_t              mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         count_q;
   logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
   logic                invalid_pulse_q;
   logic [CHW-1:0]      invalid_ch_q;

   logic [NUM_CH-1:0]   code_bad;
   logic [NUM_CH-1:0]   req;
   logic [NUM_CH-1:0]   grant;
   logic [CHW-1:0]      grant_idx;
   logic                any_grant;
   logic                full;
   logic                push;
   logic                pop;
   logic                grant_bad;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot.
   assign full = (count_q == (AW+1)'(FIFO_DEPTH));

   // Out-of-range codes bypass the full check since they never occupy the queue.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_req
      assign code_bad[i] = (32'(sel_item[i*W +: W]) >= 32'(NUM_ITEMS));
      assign req[i]      = sel_valid[i] && (code_bad[i] || !full);
   end

   rr_arbiter #(
      .N  (NUM_CH),
      .IW (CHW)
   ) u_arb (
      .req_i       (req),
      .ptr_i       (rr_ptr_q),
      .enable_i    (rstn && !flush),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_grant_o (any_grant)
   );

   assign sel_ready = grant;
   assign grant_bad = code_bad[grant_idx];
   assign push      = any_grant && !grant_bad;
   assign pop       = (count_q != '0) && out_ready && !flush;
   assign rr_ptr_d  = (grant_idx == CHW'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;

   // Queue bookkeeping, arbitration pointer and invalid-code flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         rr_ptr_q        <= '0;
         invalid_pulse_q <= 1'b0;
         invalid_ch_q    <= '0;
      end else begin
         invalid_pulse_q <= any_grant && grant_bad;
         if (any_grant) begin
            rr_ptr_q <= rr_ptr_d;
            if (grant_bad) invalid_ch_q <= grant_idx;
         end
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
         end
      end
   end

   // Queue storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{ch: grant_idx, item: sel_item[grant_idx*W +: W]};
   end

   assign out_valid     = (count_q != '0);
   assign out_item      = mem_q[rd_ptr_q].item;
   assign out_ch        = mem_q[rd_ptr_q].ch;
   assign fifo_count    = count_q;
   assign invalid_pulse = invalid_pulse_q;
   assign invalid_ch    = invalid_ch_q;

`ifdef ITEM_SEL_STATS_EN
   logic [15:0] accept_cnt_q, reject_cnt_q;

   // Saturating activity counters; cleared only by reset, not by flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         accept_cnt_q <= '0;
         reject_cnt_q <= '0;
      end else begin
         if (push && accept_cnt_q != 16'hFFFF) accept_cnt_q <= accept_cnt_q + 1'b1;
         if (any_grant && grant_bad && reject_cnt_q != 16'hFFFF)
            reject_cnt_q <= reject_cnt_q + 1'b1;
      end
   end

   assign accept_cnt = accept_cnt_q;
   assign reject_cnt = reject_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_item_select_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_item_select_queue
//  Description : Directed self-checking bench for item_select_queue at the
//                default sizing (W=10, 4 channels, depth 8, 1000 items).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_item_select_queue;

   logic        clk;
   logic        rstn;
   logic [39:0] sel_item;
   logic [3:0]  sel_valid;
   logic [3:0]  sel_ready;
   logic        flush;
   logic [9:0]  out_item;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
   logic        invalid_pulse;
   logic [1:0]  invalid_ch;
   logic [3:0]  fifo_count;
`ifdef ITEM_SEL_STATS_EN
   logic [15:0] accept_cnt;
   logic [15:0] reject_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   item_select_queue dut (
      .clk           (clk),
      .rstn          (rstn),
      .sel_item      (sel_item),
      .sel_valid     (sel_valid),
      .sel_ready     (sel_ready),
      .flush         (flush),
      .out_item      (out_item),
      .out_ch        (out_ch),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .invalid_pulse (invalid_pulse),
      .invalid_ch    (invalid_ch),
      .fifo_count    (fifo_count)
`ifdef ITEM_SEL_STATS_EN
      ,
      .accept_cnt    (accept_cnt),
      .reject_cnt    (reject_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_item(input int ch, input logic [9:0] code);
      sel_item[ch*10 +: 10] = code;
   endtask

   task automatic test_reset();
      rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
      sel_item = '0; sel_valid = 4'hF;
      #12;
      n_checks++; if (sel_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", sel_ready); else n_pass++;
      n_checks++; if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (invalid_pulse !== 1'b0) $display("FAIL reset_invalid: got %b want 0", invalid_pulse); else n_pass++;
      @(negedge clk);
      sel_valid = 4'h0;
      rstn = 1'b1;
   endtask

   task automatic test_single_push();
      set_item(2, 10'd37); sel_valid = 4'b0100; out_ready = 1'b0;
      #1;
      n_checks++; if (sel_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", sel_ready); else n_pass++;
      cyc();
      sel_valid = 4'b0000;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
      n_checks++; if (out_item !== 10'd37) $display("FAIL single_item: got %0d want 37", out_item); else n_pass++;
      n_checks++; if (out_ch !== 2'd2) $display("FAIL single_ch: got %0d want 2", out_ch); else n_pass++;
      n_checks++; if (fifo_count !== 4'd1) $display("FAIL single_count: got %0d want 1", fifo_count); else n_pass++;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      n_checks++; if (fifo_count !== 4'd0) $display("FAIL single_drain: got %0d want 0", fifo_count); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_ready;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) set_item(i, 10'(100 + i));
      sel_valid = 4'hF; out_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         exp_ready = 4'b0001 << (k % 4);
         n_checks++; if (sel_ready !== exp_ready) $display("FAIL fair_grant%0d: got %b want %b", k, sel_ready, exp_ready); else n_pass++;
         cyc();
         n_checks++; if (out_ch !== 2'(k % 4) || out_item !== 10'(100 + k % 4) || fifo_count !== 4'd1)
            $display("FAIL fair_head%0d: got ch%0d item%0d cnt%0d want ch%0d item%0d cnt1", k, out_ch, out_item, fifo_count, k % 4, 100 + k % 4);
         else n_pass++;
      end
      sel_valid = 4'h0;
      cyc();
      out_ready = 1'b0;
      n_checks++; if (fifo_count !== 4'd0) $display("FAIL fair_drain: got %0d want 0", fifo_count); else n_pass++;
   endtask

   // rr_ptr is 1 here.
   task automatic test_full();
      sel_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         set_item(0, 10'(10 + k));
         cyc();
      end
      sel_valid = 4'b0010; set_item(1, 10'd5);
      #1;
      n_checks++; if (sel_ready !== 4'b0000) $display("FAIL full_block: got %b want 0000", sel_ready); else n_pass++;
      n_checks++; if (fifo_count !== 4'd8) $display("FAIL full_count: got %0d want 8", fifo_count); else n_pass++;
      cyc();
      set_item(1, 10'd1000);
      #1;
      n_checks++; if (sel_ready !== 4'b0010) $display("FAIL bad_accept: got %b want 0010", sel_ready); else n_pass++;
      cyc();
      sel_valid = 4'b0000;
      n_checks++; if (invalid_pulse !== 1'b1 || invalid_ch !== 2'd1)
         $display("FAIL bad_pulse: got pulse%b ch%0d want pulse1 ch1", invalid_pulse, invalid_ch);
      else n_pass++;
      n_checks++; if (fifo_count !== 4'd8) $display("FAIL bad_not_pushed: got %0d want 8", fifo_count); else n_pass++;
      cyc();
      n_checks++; if (invalid_pulse !== 1'b0) $display("FAIL bad_pulse_width: got %b want 0", invalid_pulse); else n_pass++;
      n_checks++; if (out_item !== 10'd10 || out_ch !== 2'd0) $display("FAIL head_stable: got item%0d ch%0d want item10 ch0", out_item, out_ch); else n_pass++;
`ifdef ITEM_SEL_STATS_EN
      n_checks++; if (reject_cnt !== 16'd1) $display("FAIL reject_cnt: got %0d want 1", reject_cnt); else n_pass++;
`endif
   endtask

   // Queue full, rr_ptr is 2.
   task automatic test_full_pop();
      out_ready = 1'b1; sel_valid = 4'b1000; set_item(3, 10'd55);
      #1;
      n_checks++; if (sel_ready !== 4'b0000) $display("FAIL fullpop_ready: got %b want 0000", sel_ready); else n_pass++;
      cyc();
      out_ready = 1'b0;
      n_checks++; if (fifo_count !== 4'd7) $display("FAIL fullpop_count: got %0d want 7", fifo_count); else n_pass++;
      n_checks++; if (out_item !== 10'd11) $display("FAIL fullpop_head: got %0d want 11", out_item); else n_pass++;
      n_checks++; if (sel_ready !== 4'b1000) $display("FAIL fullpop_late: got %b want 1000", sel_ready); else n_pass++;
      cyc();
      sel_valid = 4'b0000;
      n_checks++; if (fifo_count !== 4'd8) $display("FAIL fullpop_refill: got %0d want 8", fifo_count); else n_pass++;
   endtask

   // rr_ptr is 0.
   task automatic test_flush();
      out_ready = 1'b1;
      repeat (3) cyc();
      out_ready = 1'b0;
      n_checks++; if (fifo_count !== 4'd5) $display("FAIL flush_pre: got %0d want 5", fifo_count); else n_pass++;
      flush = 1'b1; out_ready = 1'b1; sel_valid = 4'b0001; set_item(0, 10'd7);
      #1;
      n_checks++; if (sel_ready !== 4'b0000) $display("FAIL flush_grant: got %b want 0000", sel_ready); else n_pass++;
      cyc();
      n_checks++; if (fifo_count !== 4'd0 || out_valid !== 1'b0)
         $display("FAIL flush_clear: got cnt%0d valid%b want cnt0 valid0", fifo_count, out_valid);
      else n_pass++;
      flush = 1'b0; out_ready = 1'b0; sel_valid = 4'hF;
      for (int i = 0; i < 4; i++) set_item(i, 10'(200 + i));
      #1;
      n_checks++; if (sel_ready !== 4'b0001) $display("FAIL flush_rr_hold: got %b want 0001", sel_ready); else n_pass++;
      repeat (3) cyc();
      sel_valid = 4'h0;
      n_checks++; if (fifo_count !== 4'd3) $display("FAIL flush_refill: got %0d want 3", fifo_count); else n_pass++;
   endtask

   task automatic test_reset_mid();
      #2;
      rstn = 1'b0; sel_valid = 4'hF;
      #1;
      n_checks++; if (out_valid !== 1'b0 || fifo_count !== 4'd0)
         $display("FAIL midreset_clear: got valid%b cnt%0d want valid0 cnt0", out_valid, fifo_count);
      else n_pass++;
      n_checks++; if (sel_ready !== 4'b0000) $display("FAIL midreset_ready: got %b want 0000", sel_ready); else n_pass++;
`ifdef ITEM_SEL_STATS_EN
      n_checks++; if (accept_cnt !== 16'd0) $display("FAIL midreset_stats: got %0d want 0", accept_cnt); else n_pass++;
`endif
      @(negedge clk);
      sel_valid = 4'h0;
      rstn = 1'b1;
      cyc();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_after: got %b want 0", out_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fairness();
      test_full();
      test_full_pop();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
